rom_arbiter: RTL and testbench

Two-port, round-robin arbiter that shares the single synchronous instruction ROM between the CPU fetch port (m0) and the bus/boot-loader port (m1). Sits directly in front of the ROM and drives its word address. Returns each read word to the winning requester with fixed one-cycle latency. Supports a bounded lock so m1 can stream bursts without starving fetch.

---
 rtl/rom_arbiter.sv | 98 +++++++++
 tb/tb_rom_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between the fetch port (m0)
// and the bus port (m1), with a bounded m1 burst lock and one-cycle read return.
module rom_arbiter #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_ack,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_lock,
   output logic              m1_ack,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

   logic              rr_ptr;
   logic              owner;
   logic [CNT_W-1:0]  lock_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              both;
   logic              lock_act;
   logic              grant0;
   logic              grant1;

   // owner doubles as "last grant went to m1" because it only moves on a grant
   always_comb begin
      both     = m0_req & m1_req;
      lock_act = m1_lock & owner;
      grant0   = 1'b0;
      grant1   = 1'b0;
      if (!reset) begin
         if (both) begin
            if (lock_act) begin
               if (lock_cnt < LOCK_MAX) grant1 = 1'b1;
               else                     grant0 = 1'b1;
            end else if (rr_ptr) begin
               grant1 = 1'b1;
            end else begin
               grant0 = 1'b1;
            end
         end else begin
            grant0 = m0_req;
            grant1 = m1_req;
         end
      end
   end

   assign m0_ack = grant0;
   assign m1_ack = grant1;

   // Idle cycles replay the last granted address so the ROM address bus stays quiet
   always_comb begin
      rom_addr = addr_q;
      if (grant1)      rom_addr = m1_addr;
      else if (grant0) rom_addr = m0_addr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         lock_cnt  <= '0;
         addr_q    <= '0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         m0_rvalid <= grant0;
         m1_rvalid <= grant1;
         if (grant0 | grant1) begin
            addr_q <= rom_addr;
            owner  <= grant1;
         end
         if (both & (grant0 | grant1)) rr_ptr <= grant0;
         if (!m1_lock || grant0) begin
            lock_cnt <= '0;
         end else if (grant1 && lock_act && (lock_cnt < LOCK_MAX)) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
         end
      end
   end

   // ROM output is already registered; route it to both ports, rvalid qualifies it
   assign m0_rdata = rom_dout;
   assign m1_rdata = rom_dout;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios then random traffic,
// compared against a port-level reference model of the arbitration rules.
module tb_rom_arbiter;
   localparam int unsigned ADDR_W   = 11;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_LOCK = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              m0_req, m1_req, m1_lock;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic              m0_ack, m1_ack, m0_rvalid, m1_rvalid;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, rom_dout;
   logic [ADDR_W-1:0] rom_addr;

   logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: preferred port, last granted port, locked run length
   int                m_pref = 0;
   int                m_last = 0;
   int                m_run  = 0;
   logic [ADDR_W-1:0] m_hold = '0;

   always #5 clk = ~clk;

   always @(posedge clk) rom_dout <= rom[rom_addr];

   rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_lock(m1_lock), .m1_ack(m1_ack),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .rom_addr(rom_addr), .rom_dout(rom_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic [ADDR_W-1:0] a0,
                        input logic r1, input logic [ADDR_W-1:0] a1, input logic lk);
      m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1; m1_lock = lk;
   endtask

   // One cycle: check acks/rom_addr before the edge, update model, check return after
   task automatic step(output int win, output logic o0, output logic o1);
      logic [ADDR_W-1:0] ea;
      win = -1;
      if (!reset) begin
         if (m0_req && !m1_req)      win = 0;
         else if (m1_req && !m0_req) win = 1;
         else if (m0_req && m1_req) begin
            if (m1_lock && m_last == 1) win = (m_run < int'(MAX_LOCK)) ? 1 : 0;
            else                        win = m_pref;
         end
      end
      ea = (win == 0) ? m0_addr : (win == 1) ? m1_addr : m_hold;
      #1;
      o0 = m0_ack;
      o1 = m1_ack;
      chk("m0_ack", 32'(m0_ack), 32'(win == 0));
      chk("m1_ack", 32'(m1_ack), 32'(win == 1));
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      @(posedge clk);
      if (reset) begin
         m_pref = 0; m_last = 0; m_run = 0; m_hold = '0;
      end else begin
         if (m0_req && m1_req && win >= 0) m_pref = 1 - win;
         if (!m1_lock || win == 0) m_run = 0;
         else if (win == 1 && m_last == 1 && m_run < int'(MAX_LOCK)) m_run++;
         if (win >= 0) begin m_last = win; m_hold = ea; end
      end
      #1;
      chk("m0_rvalid", 32'(m0_rvalid), 32'(win == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(win == 1));
      if (win == 0) chk("m0_rdata", m0_rdata, rom[ea]);
      if (win == 1) chk("m1_rdata", m1_rdata, rom[ea]);
      @(negedge clk);
   endtask

   initial begin
      int   w;
      logic o0, o1;
      logic [5:0] lock_seq;
      logic [3:0] rr_seq;
      int   n_m0_ack;

      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = $urandom;

      // reset held with both ports requesting
      reset = 1'b1;
      drive(1'b1, 11'h012, 1'b1, 11'h034, 1'b0);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(w, o0, o1);
      reset = 1'b0;
      step(w, o0, o1);
      chk("first_grant_m0", 32'(o0), 32'd1);

      // single port streaming
      n_m0_ack = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, ADDR_W'(i), 1'b0, 11'h000, 1'b0);
         step(w, o0, o1);
         if (o0) n_m0_ack++;
      end
      chk("stream_acks", 32'(n_m0_ack), 32'd10);

      // round-robin with both requesting
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 11'h010, 1'b1, 11'h020, 1'b0);
         step(w, o0, o1);
         rr_seq[i] = o1;
      end
      chk("rr_alternate", 32'(rr_seq), 32'(4'b0101));

      // lock bound: m0 grant, one unlocked m1 grant, then both with lock
      drive(1'b1, 11'h030, 1'b0, 11'h040, 1'b0);
      step(w, o0, o1);
      drive(1'b0, 11'h030, 1'b1, 11'h040, 1'b1);
      step(w, o0, o1);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 11'h030, 1'b1, ADDR_W'(11'h041 + i), 1'b1);
         step(w, o0, o1);
         lock_seq[i] = o1;
      end
      chk("lock_bound", 32'(lock_seq), 32'(6'b101111));

      // idle hold after a grant at the top address
      drive(1'b0, 11'h000, 1'b1, 11'h7FF, 1'b0);
      step(w, o0, o1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, ADDR_W'(i), 1'b0, ADDR_W'(i + 3), 1'b0);
         step(w, o0, o1);
      end
      #1 chk("idle_hold", 32'(rom_addr), 32'(11'h7FF));

      // reset in a grant cycle clears round-robin pointer
      @(negedge clk);
      drive(1'b1, 11'h050, 1'b1, 11'h060, 1'b0);
      step(w, o0, o1);
      drive(1'b1, 11'h005, 1'b0, 11'h060, 1'b0);
      reset = 1'b1;
      step(w, o0, o1);
      reset = 1'b0;
      drive(1'b1, 11'h006, 1'b1, 11'h061, 1'b0);
      step(w, o0, o1);
      chk("post_reset_m0", 32'(o0), 32'd1);

      // random traffic; requests held until accepted
      for (int i = 0; i < 400; i++) begin
         if (!(m0_req && w != 0)) begin
            m0_req  = ($urandom_range(0, 2) != 0);
            m0_addr = ADDR_W'($urandom);
         end
         if (!(m1_req && w != 1)) begin
            m1_req  = ($urandom_range(0, 2) != 0);
            m1_addr = ADDR_W'($urandom);
         end
         m1_lock = ($urandom_range(0, 3) != 0);
         reset   = ($urandom_range(0, 49) == 0);
         step(w, o0, o1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
